// File: rtl/bus_key_responder.sv
// Bus-snooping key responder: a nibble sequence on qualified reads unlocks an
// LFSR keystream that advances on every qualified read until a write or timeout relocks it.
module bus_key_responder #(
    parameter int                           STATE_W    = 6,
    parameter int                           DOUT_W     = 2,
    parameter int                           UNLOCK_LEN = 4,
    parameter logic [4*UNLOCK_LEN-1:0]      UNLOCK_SEQ = 16'hC3A5,
    parameter logic [STATE_W-1:0]           TAPS       = 6'h30,
    parameter logic [STATE_W-1:0]           SEED       = 6'h21,
    parameter logic [DOUT_W*STATE_W-1:0]    OUT_MASK   = {6'h16, 6'h29},
    parameter int                           TIMEOUT    = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               acc_stb,
    input  logic               sser,
    input  logic               ba13,
    input  logic               ba12,
    input  logic [3:0]         ba_nib,
    input  logic               br_w,
    output logic [DOUT_W-1:0]  dout,
    output logic               dout_oe,
    output logic               unlocked,
    output logic [STATE_W-1:0] state_o
);
    localparam int IDX_W = (UNLOCK_LEN > 1) ? $clog2(UNLOCK_LEN) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(UNLOCK_LEN - 1);
    localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
    localparam logic [15:0]      IDLE_LAST = 16'(TIMEOUT - 1);

    typedef enum logic {LOCKED, RUN} fsm_t;

    fsm_t               fsm;
    logic [IDX_W-1:0]   idx;
    logic [STATE_W-1:0] state;
    logic [15:0]        idle_cnt;
    logic               win;
    logic               qual;
    logic [3:0]         exp_nib;
    logic [STATE_W-1:0] lfsr_next;

    assign win     = ~sser & ~ba13 & ba12;
    assign qual    = acc_stb & win;
    assign exp_nib = UNLOCK_SEQ[{idx, 2'b00} +: 4];

    // All-zero is a lock-up state for an XOR LFSR, so it is replaced by 1.
    always_comb begin
        lfsr_next = {state[STATE_W-2:0], ^(state & TAPS)};
        if (lfsr_next == '0)
            lfsr_next = STATE_W'(1);
    end

    genvar k;
    generate
        for (k = 0; k < DOUT_W; k++) begin : g_dout
            assign dout[k] = ^(state & OUT_MASK[k*STATE_W +: STATE_W]);
        end
    endgenerate

    assign dout_oe  = rst_n & (fsm == RUN) & qual & br_w;
    assign unlocked = (fsm == RUN);
    assign state_o  = state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm      <= LOCKED;
            idx      <= '0;
            state    <= '0;
            idle_cnt <= '0;
        end else begin
            case (fsm)
                LOCKED: begin
                    if (qual) begin
                        if (!br_w) begin
                            idx <= '0;
                        end else if (ba_nib == exp_nib) begin
                            if (idx == IDX_LAST) begin
                                idx      <= '0;
                                state    <= SEED;
                                idle_cnt <= '0;
                                fsm      <= RUN;
                            end else begin
                                idx <= idx + 1'b1;
                            end
                        end else begin
                            // A mismatching nibble may itself be the start of a new attempt.
                            idx <= (ba_nib == UNLOCK_SEQ[3:0]) ? IDX_ONE : '0;
                        end
                    end
                end
                RUN: begin
                    if (qual) begin
                        idle_cnt <= '0;
                        if (br_w) begin
                            state <= lfsr_next;
                        end else begin
                            fsm   <= LOCKED;
                            idx   <= '0;
                            state <= '0;
                        end
                    end else if (idle_cnt == IDLE_LAST) begin
                        fsm      <= LOCKED;
                        idx      <= '0;
                        state    <= '0;
                        idle_cnt <= '0;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
                default: fsm <= LOCKED;
            endcase
        end
    end
endmodule

// File: doc/bus_key_responder.md
BUS_KEY_RESPONDER -- requirements
Module: bus_key_responder

Interface
REQ-001 SHALL have parameters: STATE_W, default 6, LFSR state width (3..16).
REQ-002 SHALL have parameters: DOUT_W, default 2, keystream bits per read (1..8).
REQ-003 SHALL have parameters: UNLOCK_LEN, default 4, number of nibbles in the unlock sequence (1..8).
REQ-004 SHALL have parameters: UNLOCK_SEQ, default 16'hC3A5, 4*UNLOCK_LEN bits; nibble i is bits [4i+3:4i]; nibble 0 is matched first.
REQ-005 SHALL have parameters: TAPS, default 6'h30, STATE_W-bit feedback mask.
REQ-006 SHALL have parameters: SEED, default 6'h21, STATE_W-bit nonzero load value.
REQ-007 SHALL have parameters: OUT_MASK, default {6'h16,6'h29}, DOUT_W*STATE_W bits; slice k drives dout[k].
REQ-008 SHALL have parameters: TIMEOUT, default 255, idle cycles in RUN before relock (1..65535).
REQ-009 SHALL have ports: clk  in  1  sole clock; all state changes on its rising edge.
REQ-010 SHALL have ports: rst_n  in  1  synchronous, active-low reset.
REQ-011 SHALL have ports: acc_stb  in  1  one-cycle pulse marking a bus access.
REQ-012 SHALL have ports: sser  in  1  active-low chip select.
REQ-013 SHALL have ports: ba13  in  1  address bit 13.
REQ-014 SHALL have ports: ba12  in  1  address bit 12.
REQ-015 SHALL have ports: ba_nib  in  4  address bits 7..4.
REQ-016 SHALL have ports: br_w  in  1  1 = read, 0 = write.
REQ-017 SHALL have ports: dout  out  DOUT_W  keystream bits.
REQ-018 SHALL have ports: dout_oe  out  1  drive enable for dout.
REQ-019 SHALL have ports: unlocked  out  1  high in RUN.
REQ-020 SHALL have ports: state_o  out  STATE_W  current LFSR state, for debug.

Function
REQ-021 SHALL define win = ~sser & ~ba13 & ba12; a qualified access is acc_stb & win.
REQ-022 SHALL implement FSM states LOCKED and RUN, with a match index idx (0..UNLOCK_LEN-1).
REQ-023 SHALL, in LOCKED, on a qualified read with ba_nib == nibble idx: increment idx; if idx was UNLOCK_LEN-1, load state with SEED, set idx to 0 and enter RUN on that edge.
REQ-024 SHALL, in LOCKED, on a qualified read with a mismatch: set idx to 1 if ba_nib == nibble 0, else 0.
REQ-025 SHALL, in LOCKED, on a qualified write: set idx to 0.
REQ-026 SHALL hold idx and state unchanged on cycles without a qualified access.
REQ-027 SHALL set dout[k] = XOR-reduce(state & OUT_MASK slice k), combinationally from the current state, valid in the same cycle as the access.
REQ-028 SHALL set dout_oe = (FSM==RUN) & acc_stb & win & br_w, combinationally; dout_oe SHALL be 0 in LOCKED.
REQ-029 SHALL, in RUN, on a qualified read, advance the LFSR on that edge: state <= {state[STATE_W-2:0], XOR-reduce(state & TAPS)}.
REQ-030 SHALL, if an advance yields all-zero, load 1 instead.
REQ-031 SHALL, in RUN, on a qualified write: enter LOCKED, set idx to 0 and set state to 0.
REQ-032 SHALL, in RUN, increment an idle counter on each cycle without a qualified access and clear it on each qualified access.
REQ-033 SHALL, when the idle counter reaches TIMEOUT, enter LOCKED and clear state, idx and counter on that edge.
REQ-034 SHALL, on simultaneous qualified access and timeout, let the access win: the counter clears and no relock occurs.
REQ-035 SHALL ignore accesses with sser=1, ba13=1 or ba12=0 in every state; they SHALL NOT count as activity for the idle counter.
REQ-036 SHALL drive unlocked = (FSM==RUN) and state_o = state, both directly from registers.

Reset
REQ-037 SHALL, on rst_n=0 at a clock edge, set FSM=LOCKED, idx=0, state=0 and idle counter=0, and force unlocked=0 and dout_oe=0, overriding any concurrent access.
REQ-038 SHALL, on reset asserted mid-RUN or mid-match, discard progress; a full unlock sequence SHALL be required afterwards.

Verification
REQ-039 SHALL verify: reset, then qualified reads with nibbles 5,A,3,C -> unlocked=1, state_o=0x21 after the fourth edge; dout_oe=0 during all four.
REQ-040 SHALL verify: first RUN read -> dout=2'b00, dout_oe=1 that cycle; state_o=0x03 after the edge; second read -> dout[0]=1, dout[1]=1 from 0x03.
REQ-041 SHALL verify: nibbles 5,A,5,A,3,C -> unlocks on the sixth access (mismatch on the third access restarts the match at idx=1).
REQ-042 SHALL verify: in RUN, a qualified write -> unlocked=0 and state_o=0 next cycle; a following read keeps dout_oe=0.
REQ-043 SHALL verify: in RUN, 255 idle cycles -> relock; a read on cycle 255 -> stays RUN; reads with sser=1 do not prevent timeout.
REQ-044 SHALL verify: rst_n=0 pulsed after nibbles 5,A -> subsequent 3,C does not unlock, and 5,A,3,C does unlock.
